pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Program-counter register and instruction-fetch sequencer. It consumes the
//  next-PC value produced by the PC-select 2:1 mux (PC+4 vs branch target),
//  holds the architectural PC, and exports PC+4 back to that mux's In1 input.
//  It fetches one word from instruction memory over a req/ack handshake and
//  delivers it to decode over a valid/ready handshake. Branch redirects flush it.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
// PORTS
//  Clk        in   1   clock, all state updates on rising edge
//  Rst_n      in   1   asynchronous, active-low reset
//  NextPC     in   32  PC-select mux output; loaded as new PC (see BEHAVIOUR)
//  Redirect   in   1   1-cycle pulse: branch taken, NextPC holds target
//  PC         out  32  current fetch PC
//  PCPlus4    out  32  PC + 4, combinational, modulo 2^32
//  IMemReq    out  1   fetch request
//  IMemAddr   out  32  fetch address (= PC while IMemReq=1)
//  IMemAck    in   1   memory returns IMemData this cycle
//  IMemData   in   32  fetched instruction word
//  InstrValid out  1   Instr/InstrPC valid for decode
//  Instr      out  32  fetched instruction
//  InstrPC    out  32  address Instr was fetched from
//  DecReady   in   1   decode accepts Instr when InstrValid=1
// BEHAVIOUR
//  Reset (Rst_n=0, async, no clock needed): PC=RESET_PC, state=HOLD,
//   Drop=0, RedirTarget=0, IMemReq=0, InstrValid=0, Instr=0, InstrPC=0.
//  PC[1:0] always 0: NextPC[1:0] ignored on every load.
//  States (registered; IMemReq = state==REQ, IMemAddr = PC):
//   HOLD: if Redirect -> InstrValid<=0, PC<=NextPC, ->REQ.
//         elif !InstrValid or DecReady -> InstrValid<=0, ->REQ. else stay.
//   REQ : IMemReq and IMemAddr held stable until IMemAck (protocol rule).
//    ack & !Drop & !Redirect: Instr<=IMemData, InstrPC<=PC, InstrValid<=1,
//         PC<=NextPC (mux supplies PCPlus4 when no branch), ->HOLD.
//    ack & Redirect: data dropped, Drop<=0, PC<=NextPC, stay REQ.
//    ack & Drop & !Redirect: data dropped, Drop<=0, PC<=RedirTarget, stay REQ.
//    !ack & Redirect: Drop<=1, RedirTarget<=NextPC; PC unchanged.
//   Staying in REQ after an ack starts a new request next cycle at new PC.
//  Redirect while Drop=1: RedirTarget overwritten (latest redirect wins).
//  Redirect kills any held output: InstrValid<=0 next edge; a DecReady in
//   the redirect cycle is not a transfer (decode squashes on Redirect).
//  Dropped words never assert InstrValid.
//  Throughput: zero-wait memory and DecReady=1 -> one instruction per 2 clocks.
//  Latency: IMemAck at edge t -> InstrValid=1 after edge t.
//  First request: IMemReq=0 first cycle after reset release, 1 the next.
//  PCPlus4 wraps: PC=32'hFFFF_FFFC -> PCPlus4=0.
// TESTING
//  T1 RESET_PC=0, ack same cycle as req, DecReady=1, NextPC=PCPlus4 ->
//     InstrPC sequence 0,4,8,C; InstrValid high every second cycle.
//  T2 DecReady=0 for 5 cycles while InstrValid=1 -> Instr/InstrPC stable,
//     IMemReq=0; DecReady=1 -> IMemReq=1 next cycle with addr=old PC+4.
//  T3 IMemAck delayed 3 cycles -> IMemReq=1, IMemAddr constant all 3 cycles.
//  T4 Redirect NextPC=0x100 while req to 0x8 pending, ack 2 cycles later ->
//     word dropped, no InstrValid, next IMemAddr=0x100; redirect in HOLD with
//     InstrValid=1 -> InstrValid=0 next cycle, next IMemAddr=target.
//  T5 Redirect and IMemAck same cycle, NextPC=0x40 -> data dropped,
//     IMemAddr=0x40 next cycle; two redirects (0x40,0x80) before ack -> 0x80.
//  T6 Rst_n low mid-request between edges -> outputs reset immediately;
//     RESET_PC=32'hFFFF_FFFC -> PCPlus4=0, NextPC=0x13 loads PC=0x10.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Holds the architectural PC and sequences one-word instruction fetches.
//   NextPC comes from the external PC-select mux (PC+4 or branch target).
//   PCPlus4 feeds back to that mux. A fetch runs over a req/ack handshake to
//   instruction memory, and the fetched word goes to decode over valid/ready.
//   A Redirect pulse flushes any in-flight or held word.
// Ports
//   Clk, Rst_n           clock, asynchronous active-low reset
//   NextPC, Redirect     next PC from the mux, branch-taken pulse
//   PC, PCPlus4          current PC and PC+4 (combinational, wraps)
//   IMemReq/Addr/Ack/Data  instruction memory handshake
//   InstrValid/Instr/InstrPC, DecReady  decode handshake
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic [31:0] NextPC,
   input  logic        Redirect,
   output logic [31:0] PC,
   output logic [31:0] PCPlus4,
   output logic        IMemReq,
   output logic [31:0] IMemAddr,
   input  logic        IMemAck,
   input  logic [31:0] IMemData,
   output logic        InstrValid,
   output logic [31:0] Instr,
   output logic [31:0] InstrPC,
   input  logic        DecReady
);

   typedef enum logic {HOLD, REQ} state_t;

   state_t      state, state_n;
   logic [31:0] pc_q, pc_n;
   logic        drop, drop_n;
   logic [31:0] redir_tgt, tgt_n;
   logic        vld_q, vld_n;
   logic [31:0] instr_q, instr_n;
   logic [31:0] ipc_q, ipc_n;
   logic [31:0] np;

   // PC is always word aligned; the low bits of any loaded value are ignored.
   assign np = NextPC & 32'hFFFF_FFFC;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state     <= HOLD;
         pc_q      <= RESET_PC & 32'hFFFF_FFFC;
         drop      <= 1'b0;
         redir_tgt <= 32'h0;
         vld_q     <= 1'b0;
         instr_q   <= 32'h0;
         ipc_q     <= 32'h0;
      end else begin
         state     <= state_n;
         pc_q      <= pc_n;
         drop      <= drop_n;
         redir_tgt <= tgt_n;
         vld_q     <= vld_n;
         instr_q   <= instr_n;
         ipc_q     <= ipc_n;
      end
   end

   always_comb begin
      state_n = state;
      pc_n    = pc_q;
      drop_n  = drop;
      tgt_n   = redir_tgt;
      vld_n   = vld_q;
      instr_n = instr_q;
      ipc_n   = ipc_q;
      case (state)
         HOLD: begin
            if (Redirect) begin
               // Held word is squashed; decode ignores DecReady this cycle.
               vld_n   = 1'b0;
               pc_n    = np;
               state_n = REQ;
            end else if (!vld_q || DecReady) begin
               vld_n   = 1'b0;
               state_n = REQ;
            end
         end
         REQ: begin
            if (IMemAck) begin
               if (Redirect) begin
                  drop_n = 1'b0;
                  pc_n   = np;
               end else if (drop) begin
                  // Word belongs to the old path; restart at the saved target.
                  drop_n = 1'b0;
                  pc_n   = redir_tgt;
               end else begin
                  instr_n = IMemData;
                  ipc_n   = pc_q;
                  vld_n   = 1'b1;
                  pc_n    = np;
                  state_n = HOLD;
               end
            end else if (Redirect) begin
               // Address must stay stable until ack, so park the target.
               drop_n = 1'b1;
               tgt_n  = np;
            end
         end
      endcase
   end

   assign PC         = pc_q;
   assign PCPlus4    = pc_q + 32'd4;
   assign IMemReq    = (state == REQ);
   assign IMemAddr   = pc_q;
   assign InstrValid = vld_q;
   assign Instr      = instr_q;
   assign InstrPC    = ipc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic        redirect, frc, ack, rdy;
   logic [31:0] tgt;
   logic [31:0] next_pc;

   logic [31:0] pc1, pcp4_1, addr1, instr1, ipc1;
   logic        req1, vld1;
   logic [31:0] pc2, pcp4_2, addr2, instr2, ipc2;
   logic        req2, vld2;
   logic [31:0] data1, data2;

   typedef struct {logic [31:0] pc; logic [31:0] instr;} exp_t;
   exp_t sbq[$];

   int total = 0;
   int fails = 0;

   always #5 Clk = ~Clk;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'd3) ^ 32'hDEAD_BEEF;
   endfunction

   // External PC-select mux model: branch target on redirect/override, else PC+4.
   assign next_pc = (redirect || frc) ? tgt : pcp4_1;
   assign data1   = memf(addr1);
   assign data2   = memf(addr2);

   pc_fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
      .Clk(Clk), .Rst_n(Rst_n), .NextPC(next_pc), .Redirect(redirect),
      .PC(pc1), .PCPlus4(pcp4_1), .IMemReq(req1), .IMemAddr(addr1),
      .IMemAck(ack), .IMemData(data1), .InstrValid(vld1), .Instr(instr1),
      .InstrPC(ipc1), .DecReady(rdy));

   pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (
      .Clk(Clk), .Rst_n(Rst_n), .NextPC(next_pc), .Redirect(redirect),
      .PC(pc2), .PCPlus4(pcp4_2), .IMemReq(req2), .IMemAddr(addr2),
      .IMemAck(ack), .IMemData(data2), .InstrValid(vld2), .Instr(instr2),
      .InstrPC(ipc2), .DecReady(rdy));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] a);
      exp_t e;
      e.pc    = a;
      e.instr = memf(a);
      sbq.push_back(e);
   endtask

   // Drive one cycle of inputs, score any word on the decode port, advance.
   task automatic cyc(input logic a, input logic r, input logic red,
                      input logic f, input logic [31:0] t);
      ack = a; rdy = r; redirect = red; frc = f; tgt = t;
      #1;
      if (vld1) begin
         chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
         if (sbq.size() != 0) begin
            chk("sb_instrpc", ipc1, sbq[0].pc);
            chk("sb_instr", instr1, sbq[0].instr);
            if (r || red) void'(sbq.pop_front());
         end
      end
      @(posedge Clk);
      #2;
   endtask

   initial begin
      Rst_n = 1'b0; redirect = 0; frc = 0; ack = 0; rdy = 0; tgt = 0;
      @(posedge Clk);
      #2;
      chk("rst_pc", pc1, 32'h0);
      chk("rst_pcplus4", pcp4_1, 32'h4);
      chk("rst_req", 32'(req1), 32'h0);
      chk("rst_valid", 32'(vld1), 32'h0);
      chk("rst_instr", instr1, 32'h0);
      chk("rst_instrpc", ipc1, 32'h0);
      Rst_n = 1'b1;
      chk("first_cycle_req", 32'(req1), 32'h0);
      cyc(0, 1, 0, 0, 0);

      // T1: zero-wait memory, decode always ready
      for (int i = 0; i < 4; i++) begin
         chk("t1_req", 32'(req1), 32'h1);
         chk("t1_addr", addr1, 32'(i * 4));
         push(32'(i * 4));
         cyc(1, 1, 0, 0, 0);
         chk("t1_valid_hi", 32'(vld1), 32'h1);
         chk("t1_req_lo", 32'(req1), 32'h0);
         cyc(0, 1, 0, 0, 0);
         chk("t1_valid_lo", 32'(vld1), 32'h0);
      end

      // T2: decode stalls with a held word
      chk("t2_addr", addr1, 32'h10);
      push(32'h10);
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         chk("t2_valid", 32'(vld1), 32'h1);
         chk("t2_req_lo", 32'(req1), 32'h0);
         chk("t2_instrpc", ipc1, 32'h10);
         cyc(0, 0, 0, 0, 0);
      end
      cyc(0, 1, 0, 0, 0);
      chk("t2_req_after", 32'(req1), 32'h1);
      chk("t2_addr_after", addr1, 32'h14);

      // T3: ack delayed 3 cycles
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1, 0, 0, 0);
         chk("t3_req", 32'(req1), 32'h1);
         chk("t3_addr", addr1, 32'h14);
      end
      push(32'h14);
      cyc(1, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      chk("t3_next_addr", addr1, 32'h18);

      // T4: redirect while request pending, ack two cycles later
      cyc(0, 1, 1, 0, 32'h100);
      chk("t4_addr_held", addr1, 32'h18);
      cyc(0, 1, 0, 0, 0);
      chk("t4_addr_held2", addr1, 32'h18);
      cyc(1, 1, 0, 0, 0);
      chk("t4_drop_valid", 32'(vld1), 32'h0);
      chk("t4_req", 32'(req1), 32'h1);
      chk("t4_addr_tgt", addr1, 32'h100);
      push(32'h100);
      cyc(1, 1, 0, 0, 0);
      chk("t4_valid", 32'(vld1), 32'h1);
      cyc(0, 1, 1, 0, 32'h200);
      chk("t4_hold_kill", 32'(vld1), 32'h0);
      chk("t4_hold_addr", addr1, 32'h200);

      // T5: redirect with ack, then two redirects before ack
      cyc(1, 1, 1, 0, 32'h40);
      chk("t5_valid", 32'(vld1), 32'h0);
      chk("t5_addr", addr1, 32'h40);
      cyc(0, 1, 1, 0, 32'h300);
      chk("t5_addr_held", addr1, 32'h40);
      cyc(0, 1, 1, 0, 32'h80);
      cyc(1, 1, 0, 0, 0);
      chk("t5_valid2", 32'(vld1), 32'h0);
      chk("t5_latest", addr1, 32'h80);
      push(32'h80);
      cyc(1, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      chk("t5_next", addr1, 32'h84);

      // T6: asynchronous reset mid-request, wrap-around RESET_PC
      #2;
      Rst_n = 1'b0;
      #1;
      chk("t6_req", 32'(req1), 32'h0);
      chk("t6_pc", pc1, 32'h0);
      chk("t6_instr", instr1, 32'h0);
      chk("t6_instrpc", ipc1, 32'h0);
      chk("t6_pc2", pc2, 32'hFFFF_FFFC);
      chk("t6_wrap", pcp4_2, 32'h0);
      sbq.delete();
      @(posedge Clk);
      #2;
      Rst_n = 1'b1;
      cyc(0, 1, 0, 0, 0);
      chk("t6_req2", 32'(req2), 32'h1);
      chk("t6_addr2", addr2, 32'hFFFF_FFFC);
      push(32'h0);
      cyc(1, 1, 0, 1, 32'h13);
      chk("t6_align_pc", pc2, 32'h10);
      chk("t6_valid2", 32'(vld2), 32'h1);
      chk("t6_instrpc2", ipc2, 32'hFFFF_FFFC);
      chk("t6_instr2", instr2, memf(32'hFFFF_FFFC));
      cyc(0, 1, 0, 0, 0);
      chk("t6_addr1", addr1, 32'h10);
      chk("sb_drained", 32'(sbq.size()), 32'h0);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
